chicken_datapath: RTL and testbench
===================================

Name: chicken_datapath

Overview:
- Game datapath paired with the game control unit.
- Consumes the control state code M, player-count code N, card-open flag A and the keypad code key.
- Produces the status inputs the control unit branches on: start request c, match result go, and game-over win.
- Tracks each player's board position and step count, the current player, and the winner for the display logic.

Parameters:
NUM_TILES, 12, tiles on the ring board; positions wrap modulo this value (max 16)
NUM_PICS, 6, number of distinct pictures
TILE_SEED, 0, picture of tile t = (t + TILE_SEED) mod NUM_PICS
CARD_STEP, 5, card picture stride
CARD_SEED, 0, picture of card k (1..NUM_TILES) = ((k-1)*CARD_STEP + CARD_SEED) mod NUM_PICS
WIN_STEPS, 12, successful steps needed to win

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_btn  in  1  start pushbutton, synchronised level
key  in  4  keypad code; 0 = none in pick phase; 1..NUM_TILES = card index
A  in  1  card-open flag from control unit
N  in  2  player-count code; players = N+1
M  in  3  control state code
c  out  1  start pulse to control unit
go  out  1  card matched next tile (registered)
win  out  1  current player reached WIN_STEPS (registered, sticky)
cur_player  out  2  index of player whose turn it is
cur_pos  out  4  position of cur_player
positions  out  16  4x4-bit positions, player0 in [3:0]
winner  out  2  winning player index, valid while win=1
card_led  out  1  equals A (combinational)

Behaviour:
- Reset (rst=1 at posedge): c=0, go=0, win=0, cur_player=0, winner=0, all positions and step counts 0, num_players=1, start_btn history=0. Reset mid-game aborts everything; no partial update survives.
- State codes: 000 idle, 001 wait player count, 010 setup, 011 pick, 100 judge, 101 miss, 110 advance-check, 111 game over.
- Start (c):
  - Registered rising-edge detect of start_btn, qualified with M==000.
  - One-cycle pulse, then 0.
  - Holding the button gives exactly one pulse.
  - Edges seen while M!=000 are ignored.
- Setup (posedge with M==010):
  - num_players <= N+1.
  - Clear all positions and step counts; cur_player <= 0; go <= 0; win <= 0.
- Pick/latch (posedge with M==011 and key!=0):
  - go <= (key in 1..NUM_TILES) && pic_card(key) == pic_tile((cur_pos+1) mod NUM_TILES).
  - key values above NUM_TILES force go <= 0.
  - go is therefore valid throughout the following M==100 cycle (1-cycle latency).
  - key==0 in M==011: no change.
  - go otherwise holds its value until the next latch or setup.
- Judge (posedge with M==100):
  - If go=1:
    - position[cur_player] <= (pos+1) mod NUM_TILES.
    - step[cur_player] <= step+1, saturating at WIN_STEPS.
    - If step+1 >= WIN_STEPS: win <= 1 and winner <= cur_player.
    - win is therefore valid during M==110.
  - If go=0: no position change.
- Miss (posedge with M==101): cur_player <= cur_player+1, wrapping to 0 when it equals num_players-1. With one player, cur_player stays 0.
- Advance-check (M==110): no datapath update; the same player continues.
- Game over (M==111):
  - Everything holds; win stays 1.
  - c is suppressed because M!=000.
  - Only rst or a new setup clears win.
- Position arithmetic: 4-bit unsigned; wrap NUM_TILES-1 -> 0 on a step. Steps keep counting across the wrap.
- Unused state codes or unexpected M sequences: no update beyond the rules above; the block never deadlocks.

Test Plan:
- Reset, then start_btn held high 5 cycles with M=000 -> c high exactly 1 cycle, 1 cycle after the rise; all outputs 0.
- M=010 with N=2'b10, then M=011 with key=6 (card pic 1, tile1 pic 1) -> go=1 during M=100. After the M=100 edge: cur_pos=1, positions[3:0]=1, win=0.
- From player0 pos 0, key=1 (pic 0 vs tile1 pic 1) -> go=0; position unchanged. After M=101: cur_player=1. With N=2'b10, two more misses -> cur_player wraps 2 -> 0.
- key=13 in M=011 -> go=0. key=0 held in M=011 -> go unchanged.
- Parameter override WIN_STEPS=2:
  - Two matching picks (key=6, then key=5 for tile2 pic 2) -> win=1 and winner=0 during M=110.
  - Position then wraps correctly in a NUM_TILES=12 run of 12 steps (11 -> 0).
- Assert rst mid-game with win=1, M=111 -> next cycle all outputs 0. start_btn pulse in M=111 -> c stays 0.

Source files
------------

// File: rtl/chicken_datapath_if.sv
// chicken_datapath_if: control-unit/keypad inputs and game status/display outputs of the datapath
interface chicken_datapath_if;
  logic start_btn;
  logic [3:0] key;
  logic A;
  logic [1:0] N;
  logic [2:0] M;
  logic c;
  logic go;
  logic win;
  logic [1:0] cur_player;
  logic [3:0] cur_pos;
  logic [15:0] positions;
  logic [1:0] winner;
  logic card_led;
  modport master (
    output start_btn, key, A, N, M,
    input c, go, win, cur_player, cur_pos, positions, winner, card_led
  );
  modport slave (
    input start_btn, key, A, N, M,
    output c, go, win, cur_player, cur_pos, positions, winner, card_led
  );
endinterface

// File: rtl/chicken_datapath.sv
// chicken_datapath: board positions, step counts, match judging and win detection for the chicken game
module chicken_datapath #(
  parameter int NUM_TILES = 12,
  parameter int NUM_PICS  = 6,
  parameter int TILE_SEED = 0,
  parameter int CARD_STEP = 5,
  parameter int CARD_SEED = 0,
  parameter int WIN_STEPS = 12
) (
  input logic clk,
  input logic rst,
  chicken_datapath_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_SETUP = 3'b010;
  localparam logic [2:0] S_PICK  = 3'b011;
  localparam logic [2:0] S_JUDGE = 3'b100;
  localparam logic [2:0] S_MISS  = 3'b101;
  function automatic logic [3:0] pic_tile(input logic [3:0] t);
    return 4'((32'(t) + TILE_SEED) % NUM_PICS);
  endfunction
  function automatic logic [3:0] pic_card(input logic [3:0] k);
    return 4'(((32'(k) - 1) * CARD_STEP + CARD_SEED) % NUM_PICS);
  endfunction
  logic [3:0][3:0] pos_q, pos_d;
  logic [3:0][7:0] step_q, step_d;
  logic [1:0] cur_q, cur_d, winner_q, winner_d;
  logic [2:0] np_q, np_d;
  logic go_q, go_d, win_q, win_d, c_q, c_d, btn_q;
  logic [3:0] cur_pos, nxt;
  logic [7:0] step_inc;
  logic key_ok;
  assign cur_pos = pos_q[cur_q];
  assign nxt = (cur_pos == 4'(NUM_TILES - 1)) ? 4'd0 : cur_pos + 4'd1;
  assign step_inc = (step_q[cur_q] >= 8'(WIN_STEPS)) ? 8'(WIN_STEPS) : step_q[cur_q] + 8'd1;
  // keys beyond the board are treated as a miss rather than aliased onto a card
  assign key_ok = (bus.key != 4'd0) && (32'(bus.key) <= NUM_TILES);
  always_comb begin
    pos_d = pos_q;
    step_d = step_q;
    cur_d = cur_q;
    winner_d = winner_q;
    np_d = np_q;
    go_d = go_q;
    win_d = win_q;
    c_d = bus.start_btn && !btn_q && (bus.M == S_IDLE);
    if (bus.M == S_SETUP) begin
      np_d = {1'b0, bus.N} + 3'd1;
      pos_d = '0;
      step_d = '0;
      cur_d = '0;
      go_d = 1'b0;
      win_d = 1'b0;
    end else if (bus.M == S_PICK && bus.key != 4'd0) begin
      go_d = key_ok && (pic_card(bus.key) == pic_tile(nxt));
    end else if (bus.M == S_JUDGE && go_q) begin
      pos_d[cur_q] = nxt;
      step_d[cur_q] = step_inc;
      if (step_inc >= 8'(WIN_STEPS)) begin
        win_d = 1'b1;
        winner_d = cur_q;
      end
    end else if (bus.M == S_MISS) begin
      cur_d = ({1'b0, cur_q} == np_q - 3'd1) ? 2'd0 : cur_q + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      step_q <= '0;
      cur_q <= '0;
      winner_q <= '0;
      np_q <= 3'd1;
      go_q <= 1'b0;
      win_q <= 1'b0;
      c_q <= 1'b0;
      btn_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      step_q <= step_d;
      cur_q <= cur_d;
      winner_q <= winner_d;
      np_q <= np_d;
      go_q <= go_d;
      win_q <= win_d;
      c_q <= c_d;
      btn_q <= bus.start_btn;
    end
  end
  assign bus.c = c_q;
  assign bus.go = go_q;
  assign bus.win = win_q;
  assign bus.cur_player = cur_q;
  assign bus.cur_pos = cur_pos;
  assign bus.positions = pos_q;
  assign bus.winner = winner_q;
  assign bus.card_led = bus.A;
endmodule

// File: tb/tb_chicken_datapath.sv
// tb_chicken_datapath: directed checks of a default instance and a WIN_STEPS=2 instance driven in lockstep
module tb_chicken_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  chicken_datapath_if ia ();
  chicken_datapath_if ib ();
  chicken_datapath dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  chicken_datapath #(.WIN_STEPS(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  assign ib.start_btn = ia.start_btn;
  assign ib.key = ia.key;
  assign ib.A = ia.A;
  assign ib.N = ia.N;
  assign ib.M = ia.M;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pick(input logic [3:0] k);
    ia.M = 3'b011;
    ia.key = k;
    tick();
    ia.key = 4'd0;
  endtask
  task automatic judge();
    ia.M = 3'b100;
    tick();
  endtask
  task automatic setup(input logic [1:0] n);
    ia.M = 3'b010;
    ia.N = n;
    tick();
  endtask
  initial begin
    ia.start_btn = 1'b0;
    ia.key = 4'd0;
    ia.A = 1'b0;
    ia.N = 2'd0;
    ia.M = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_c", 16'(ib.c), 16'd0);
    chk("rst_go", 16'(ib.go), 16'd0);
    chk("rst_win", 16'(ib.win), 16'd0);
    chk("rst_cur", 16'(ib.cur_player), 16'd0);
    chk("rst_pos", ib.positions, 16'h0000);
    chk("rst_winner", 16'(ib.winner), 16'd0);
    ia.start_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("start_c%0d", i), 16'(ib.c), (i == 0) ? 16'd1 : 16'd0);
    end
    ia.start_btn = 1'b0;
    tick();
    ia.A = 1'b1;
    #1;
    chk("card_led1", 16'(ib.card_led), 16'd1);
    ia.A = 1'b0;
    #1;
    chk("card_led0", 16'(ib.card_led), 16'd0);
    setup(2'b10);
    pick(4'd6);
    chk("match_go", 16'(ib.go), 16'd1);
    judge();
    chk("match_cur_pos", 16'(ib.cur_pos), 16'd1);
    chk("match_pos", ib.positions, 16'h0001);
    chk("match_win", 16'(ib.win), 16'd0);
    setup(2'b10);
    chk("setup_go", 16'(ib.go), 16'd0);
    chk("setup_pos", ib.positions, 16'h0000);
    pick(4'd1);
    chk("nomatch_go", 16'(ib.go), 16'd0);
    judge();
    chk("nomatch_pos", ib.positions, 16'h0000);
    ia.M = 3'b101;
    tick();
    chk("miss1_cur", 16'(ib.cur_player), 16'd1);
    tick();
    chk("miss2_cur", 16'(ib.cur_player), 16'd2);
    tick();
    chk("miss3_wrap", 16'(ib.cur_player), 16'd0);
    pick(4'd6);
    chk("go_before_13", 16'(ib.go), 16'd1);
    pick(4'd13);
    chk("key13_go", 16'(ib.go), 16'd0);
    pick(4'd6);
    pick(4'd0);
    chk("key0_hold", 16'(ib.go), 16'd1);
    ia.M = 3'b110;
    tick();
    chk("adv_hold_go", 16'(ib.go), 16'd1);
    chk("adv_hold_pos", ib.positions, 16'h0000);
    setup(2'b01);
    pick(4'd1);
    judge();
    ia.M = 3'b101;
    tick();
    chk("p1_turn", 16'(ib.cur_player), 16'd1);
    pick(4'd6);
    judge();
    chk("p1_pos1", ib.positions, 16'h0010);
    chk("p1_cur_pos", 16'(ib.cur_pos), 16'd1);
    chk("p1_win_early", 16'(ib.win), 16'd0);
    pick(4'd5);
    chk("p1_go2", 16'(ib.go), 16'd1);
    judge();
    ia.M = 3'b110;
    tick();
    chk("p1_win", 16'(ib.win), 16'd1);
    chk("p1_winner", 16'(ib.winner), 16'd1);
    chk("p1_pos2", ib.positions, 16'h0020);
    chk("p1_default_nowin", 16'(ia.win), 16'd0);
    ia.M = 3'b101;
    tick();
    chk("p1_wrap_cur", 16'(ib.cur_player), 16'd0);
    setup(2'b00);
    chk("setup_clr_win", 16'(ib.win), 16'd0);
    for (int i = 0; i < 12; i++) begin
      int t, p;
      t = (i + 1) % 12;
      p = t % 6;
      pick(4'(((6 - p) % 6) + 1));
      chk($sformatf("wrap_go%0d", i), 16'(ia.go), 16'd1);
      judge();
      chk($sformatf("wrap_pos%0d", i), 16'(ia.cur_pos), 16'(t));
      chk($sformatf("wrap_awin%0d", i), 16'(ia.win), (i == 11) ? 16'd1 : 16'd0);
      if (i == 1) chk("wrap_bwin", 16'(ib.win), 16'd1);
    end
    chk("wrap_b_pos", 16'(ib.cur_pos), 16'd0);
    chk("wrap_a_winner", 16'(ia.winner), 16'd0);
    ia.M = 3'b111;
    tick();
    chk("over_win", 16'(ib.win), 16'd1);
    ia.start_btn = 1'b1;
    tick();
    chk("over_no_c", 16'(ib.c), 16'd0);
    tick();
    chk("over_no_c2", 16'(ib.c), 16'd0);
    ia.start_btn = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_win", 16'(ib.win), 16'd0);
    chk("mid_rst_go", 16'(ib.go), 16'd0);
    chk("mid_rst_c", 16'(ib.c), 16'd0);
    chk("mid_rst_pos", ia.positions, 16'h0000);
    chk("mid_rst_cur", 16'(ia.cur_pos), 16'd0);
    chk("mid_rst_awin", 16'(ia.win), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
